// File: rtl/muldiv_arbiter.sv
// ============================================================================
// muldiv_arbiter: two-requester round-robin front end for one iterative
// RISC-V M-extension multiply/divide engine. Optional macro: MULDIV_ALTOPS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_arbiter #(
  parameter int   WIDTH        = 32,
  parameter logic RR_RESET_PTR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [5:0]           req_op_i,
  input  logic [2*WIDTH-1:0]   req_rs1_i,
  input  logic [2*WIDTH-1:0]   req_rs2_i,
  input  logic [9:0]           req_rd_i,
  input  logic                 flush_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_id_o,
  output logic [4:0]           resp_rd_o,
  output logic [WIDTH-1:0]     resp_data_o,
  output logic                 busy_o
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q;
  logic               rr_ptr_q;
  logic [2:0]         op_q;
  logic [4:0]         rd_q;
  logic               id_q;
  logic               neg_q;
  logic               spec_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               resp_valid_q;
  logic               resp_id_q;
  logic [4:0]         resp_rd_q;
  logic [WIDTH-1:0]   resp_data_q;

  // Selected-request decode
  logic               gnt_id;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   rs1_sel;
  logic [WIDTH-1:0]   rs2_sel;
  logic [4:0]         rd_sel;
  logic               n1;
  logic               n2;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic               neg_sel;
  logic               spec_sel;
  logic [WIDTH-1:0]   spec_res;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   res_d;

  always_comb begin
    req_ready_o = 2'b00;
    if (rst_n && (state_q == IDLE) && !flush_i) begin
      case (req_valid_i)
        2'b01:   req_ready_o = 2'b01;
        2'b10:   req_ready_o = 2'b10;
        2'b11:   req_ready_o = rr_ptr_q ? 2'b10 : 2'b01;
        default: req_ready_o = 2'b00;
      endcase
    end
  end

  assign gnt_id  = req_ready_o[1];
  assign op_sel  = gnt_id ? req_op_i[5:3] : req_op_i[2:0];
  assign rs1_sel = gnt_id ? req_rs1_i[2*WIDTH-1:WIDTH] : req_rs1_i[WIDTH-1:0];
  assign rs2_sel = gnt_id ? req_rs2_i[2*WIDTH-1:WIDTH] : req_rs2_i[WIDTH-1:0];
  assign rd_sel  = gnt_id ? req_rd_i[9:5] : req_rd_i[4:0];

  always_comb begin
    logic s1;
    logic s2;
    logic div0;
    logic ovf;
    s1   = (op_sel == 3'd1) || (op_sel == 3'd2) || (op_sel == 3'd4) || (op_sel == 3'd6);
    s2   = (op_sel == 3'd1) || (op_sel == 3'd4) || (op_sel == 3'd6);
    n1   = s1 & rs1_sel[WIDTH-1];
    n2   = s2 & rs2_sel[WIDTH-1];
    abs1 = n1 ? -rs1_sel : rs1_sel;
    abs2 = n2 ? -rs2_sel : rs2_sel;
    // Remainder follows the dividend; everything else follows the sign product.
    neg_sel = op_sel[2] && op_sel[1] ? n1 : (n1 ^ n2);
    div0 = op_sel[2] && (rs2_sel == '0);
    ovf  = (op_sel == 3'd4 || op_sel == 3'd6) &&
           (rs1_sel == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_sel == '1);
`ifdef MULDIV_ALTOPS_EN
    spec_sel = 1'b1;
    case (op_sel)
      3'd0:    spec_res = (rs1_sel + rs2_sel) ^ WIDTH'(32'h5876063e);
      3'd1:    spec_res = (rs1_sel + rs2_sel) ^ WIDTH'(32'hf6583fb7);
      3'd2:    spec_res = (rs1_sel - rs2_sel) ^ WIDTH'(32'hecfbe137);
      3'd3:    spec_res = (rs1_sel + rs2_sel) ^ WIDTH'(32'h949ce5e8);
      3'd4:    spec_res = (rs1_sel - rs2_sel) ^ WIDTH'(32'h7f8529ec);
      3'd5:    spec_res = (rs1_sel - rs2_sel) ^ WIDTH'(32'h10e8fd70);
      3'd6:    spec_res = (rs1_sel - rs2_sel) ^ WIDTH'(32'h8da68fa5);
      default: spec_res = (rs1_sel - rs2_sel) ^ WIDTH'(32'h3138d0e1);
    endcase
`else
    spec_sel = div0 | ovf;
    if (div0)
      spec_res = op_sel[1] ? rs1_sel : '1;
    else
      spec_res = op_sel[1] ? '0 : rs1_sel;
`endif
  end

  // One engine step: acc holds {partial/remainder, multiplier/quotient}.
  always_comb begin
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!op_q[2])
      acc_d = {sum, acc_q[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    prod = neg_q ? -acc_q : acc_q;
    rem  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (spec_q)
      res_d = acc_q[WIDTH-1:0];
    else begin
      case (op_q)
        3'd0, 3'd4, 3'd5: res_d = prod[WIDTH-1:0];
        3'd1, 3'd2, 3'd3: res_d = prod[2*WIDTH-1:WIDTH];
        default:          res_d = rem;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= RR_RESET_PTR;
      op_q         <= 3'd0;
      rd_q         <= 5'd0;
      id_q         <= 1'b0;
      neg_q        <= 1'b0;
      spec_q       <= 1'b0;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_rd_q    <= 5'd0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready_o) begin
            rr_ptr_q <= ~gnt_id;
            op_q     <= op_sel;
            rd_q     <= rd_sel;
            id_q     <= gnt_id;
            neg_q    <= neg_sel;
            spec_q   <= spec_sel;
            if (spec_sel) begin
              acc_q   <= {{WIDTH{1'b0}}, spec_res};
              state_q <= FIXUP;
            end else begin
              opnd_q  <= op_sel[2] ? abs2 : abs1;
              acc_q   <= {{WIDTH{1'b0}}, (op_sel[2] ? abs1 : abs2)};
              cnt_q   <= ITERS;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
              state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            resp_data_q  <= res_d;
            resp_rd_q    <= rd_q;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_rd_o    = resp_rd_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Owns the single iterative multiply/divide engine and sequences it.
- Shares the engine between two requesters: requester 0 is the executor; requester 1 is reserved for a second issue path or a CSR/debug agent.
- Arbitrates round-robin, runs shift-add multiply or restoring divide on operand magnitudes, and applies RISC-V M-extension sign and corner-case rules.
- Returns a tagged result over a valid/ready response channel.

Parameters:
- WIDTH, 32: operand/result width; iteration count equals WIDTH.
- RR_RESET_PTR, 0: requester that wins the first simultaneous request after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; block is held in reset while 0.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_op  input  2x3  per-requester op, funct3 order: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- req_rs1  input  2xWIDTH  per-requester operand 1.
- req_rs2  input  2xWIDTH  per-requester operand 2.
- req_rd  input  2x5  per-requester destination tag, returned unchanged.
- flush  input  1  aborts any in-flight operation.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  index of the requester that issued the result.
- resp_rd  output  5  destination tag of the result.
- resp_data  output  WIDTH  result value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=RR_RESET_PTR.
  - resp_valid=0, resp_id=0, resp_rd=0, resp_data=0, busy=0, req_ready=0.
  - An in-flight operation is discarded with no response.
- States: IDLE, ITER, FIXUP, RESP.
- IDLE:
  - req_ready is combinational from registered state and req_valid; it is 0 whenever flush=1.
  - Only one valid: that requester gets ready.
  - Both valid: rr_ptr's requester gets ready.
  - On handshake: rr_ptr <= other index. Latch op, rd, id, abs(rs1)/abs(rs2) per op signedness, and the result sign.
  - mulh: both operands signed. mulhsu: rs1 signed, rs2 unsigned. div/rem: signed. u-variants and mul: unsigned.
  - Next state is ITER with counter=WIDTH, except div/rem special cases, which go directly to FIXUP.
- Special cases (handled in FIXUP):
  - rs2==0: div/divu -> all ones; rem/remu -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=-1): div -> 0x80000000; rem -> 0.
- ITER, one iteration per cycle, counter decrements; at counter==1 the next state is FIXUP:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step producing quotient and remainder.
- FIXUP, one cycle:
  - Negate the product, quotient or remainder as required. Remainder takes the sign of the dividend; quotient is negative when operand signs differ.
  - Select the low word for mul and the high word for mulh/mulhsu/mulhu.
  - Register resp_data, resp_rd and resp_id; resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid, resp_data, resp_rd and resp_id are held stable until resp_ready=1.
  - On the response handshake: resp_valid <= 0, state <= IDLE.
  - The next request is accepted no earlier than the cycle after the response handshake.
- Latency, counted from the accepting edge E:
  - Normal ops: resp_valid high in the cycle after edge E+WIDTH+1 (34 cycles for WIDTH=32).
  - Special cases: resp_valid high 2 cycles after E.
- flush:
  - In ITER, FIXUP or RESP: next edge returns to IDLE and resp_valid <= 0; the result is dropped; rr_ptr is unchanged.
  - Coincident with a request in IDLE: nothing is accepted.
- Starvation: a requester continuously valid behind the other waits for at most one operation.
- Requester inputs must stay stable while valid && !ready; the block does not check this.

Optional Feature:
- Macro: MULDIV_ALTOPS_EN.
- Defined (formal builds):
  - ITER is skipped; IDLE -> FIXUP -> RESP, so resp_valid is high 2 cycles after accept for every op.
  - Result is the formal alternative op:
    - mul (rs1+rs2)^0x5876063e
    - mulh (rs1+rs2)^0xf6583fb7
    - mulhsu (rs1-rs2)^0xecfbe137
    - mulhu (rs1+rs2)^0x949ce5e8
    - div (rs1-rs2)^0x7f8529ec
    - divu (rs1-rs2)^0x10e8fd70
    - rem (rs1-rs2)^0x8da68fa5
    - remu (rs1-rs2)^0x3138d0e1
- Undefined: real iterative arithmetic as specified above.

Test Plan:
- req0 mul rs1=7, rs2=0xFFFFFFFD, rd=5 -> resp_data=0xFFFFFFEB, resp_rd=5, resp_id=0, resp_valid 34 cycles after accept.
- Two high-half multiplies:
  - mulh 0x80000000 x 0x80000000 -> 0x40000000.
  - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Divide and remainder cases:
  - div -7/2 -> 0xFFFFFFFD; rem -7%2 -> 0xFFFFFFFF.
  - div 9/0 -> 0xFFFFFFFF and remu 5%0 -> 5, both in 2 cycles.
  - div 0x80000000/-1 -> 0x80000000; rem of the same -> 0.
- Both req_valid held high for 4 ops with resp_ready=1 -> grants 0,1,0,1. Then hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, no new req_ready.
- flush at the 10th ITER cycle of a divu -> no resp_valid, busy=0 next cycle; a request in the following cycle is accepted and completes normally.
- reset driven low asynchronously mid-ITER -> all outputs zero immediately. After release with both requesters valid, requester 0 is granted first (RR_RESET_PTR=0).
